y86_dmem_responder: RTL and testbench
=====================================

// Module: y86_dmem_responder
// PURPOSE
//   Data-memory responder for the Y86-64 pipeline memory stage. It accepts one
//   read or write request at a time over a valid/ready handshake. It services the
//   request from an internal byte array after a fixed number of wait states, then
//   returns data plus a Y86 status code (1=AOK, 3=ADR). Performs 8-byte
//   little-endian accesses (rmmovq/mrmovq/pushq/popq/call/ret).
// PARAMETERS
//   MEM_BYTES    1024  size of the byte array; valid addresses are 0..MEM_BYTES-1
//   WAIT_CYCLES  2     extra cycles between request acceptance and response (0..15)
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst_n      in   1   synchronous, active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_write  in   1   1 = write 8 bytes, 0 = read 8 bytes
//   req_addr   in   64  byte address of the least-significant byte
//   req_wdata  in   64  write data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts the response
//   rsp_rdata  out  64  read data (0 for writes and errors)
//   rsp_stat   out  3   1 = AOK, 3 = ADR (address error)
// BEHAVIOUR
//   - Clock and reset: one clock domain, clk. Reset is synchronous and active-low
//     (rst_n sampled on posedge clk).
//   - Reset: state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_stat=1.
//     req_ready=0 while rst_n=0. Memory contents are not reset.
//   - FSM states and transitions:
//       IDLE -> WAIT: when req_valid && req_ready. Latch write, addr, wdata;
//                     load counter with WAIT_CYCLES.
//       WAIT -> WAIT: while counter != 0; decrement counter each cycle.
//       WAIT -> RESP: when counter == 0. Commit the access on this edge.
//       RESP -> IDLE: when rsp_valid && rsp_ready.
//   - req_ready=1 only in IDLE, with rst_n=1. It is combinational from state only,
//     with no path from req_valid.
//   - Latency:
//       Request accepted at edge N; rsp_valid rises after edge N+1+WAIT_CYCLES.
//       With WAIT_CYCLES=0, rsp_valid rises after edge N+1.
//       Next request can be accepted no earlier than the cycle after the
//       response handshake completes.
//   - Address check: error when addr > MEM_BYTES-8, computed without 64-bit
//     overflow. Example: addr=2^64-4 is an error.
//   - Commit on entry to RESP:
//       read OK:  rsp_rdata = {mem[a+7],...,mem[a]}, rsp_stat=1.
//       write OK: mem[a+i] = wdata[8i+7:8i] for i=0..7; rsp_rdata=0; rsp_stat=1.
//       error:    memory untouched; rsp_rdata=0; rsp_stat=3.
//   - rsp_valid, rsp_rdata and rsp_stat hold stable in RESP until rsp_ready=1.
//     rsp_valid drops on the edge where rsp_ready=1 is sampled.
//   - req_* inputs are ignored outside IDLE. A request held by the requester is
//     not lost; it is accepted when the FSM returns to IDLE.
//   - Reset mid-operation:
//       in WAIT: request abandoned, no memory write.
//       in RESP: the write has already committed; the response is discarded.
//   - Back-to-back: a read following a write to the same address returns the
//     newly written data.
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN
//     defined:   addr[2:0] != 0 is also an address error. Response is rsp_stat=3,
//                rsp_rdata=0, no write.
//     undefined: unaligned accesses are legal and byte-exact.
// TESTING
//   1. Write then read at WAIT_CYCLES=2:
//      write addr=0x10, wdata=0x1122334455667788 -> rsp_valid 3 cycles after
//      acceptance, rsp_stat=1, rsp_rdata=0.
//      read addr=0x10 -> rsp_rdata=0x1122334455667788, rsp_stat=1;
//      mem[0x10]=0x88, mem[0x17]=0x11.
//   2. Boundary:
//      read addr=MEM_BYTES-8 -> rsp_stat=1.
//      read addr=MEM_BYTES-7 -> rsp_stat=3, rsp_rdata=0.
//      write addr=0xFFFFFFFFFFFFFFFC -> rsp_stat=3; bytes 0..3 of memory unchanged.
//   3. Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and
//      rsp_stat stable; req_ready=0 throughout. Then rsp_ready=1 -> rsp_valid=0
//      and req_ready=1 next cycle.
//   4. Reset during WAIT of a write to addr=0x20 -> after reset rsp_valid=0,
//      rsp_stat=1, req_ready=1. A following read of 0x20 returns the prior contents.
//   5. WAIT_CYCLES=0 with continuous req_valid and rsp_ready=1 -> one transaction
//      every 3 cycles (accept, respond, idle), each rsp_stat=1.
//   6. DMEM_ALIGN_CHECK_EN defined: read addr=0x11 -> rsp_stat=3.
//      Undefined: same read -> rsp_stat=1 with bytes mem[0x11..0x18].

Source files
------------

// File: rtl/y86_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : y86_dmem_responder
// Description : Data-memory responder for the Y86-64 memory stage.
//               - Takes one 8-byte read or write request at a time over a
//                 valid/ready handshake.
//               - Waits a fixed number of cycles, then services the request
//                 from an internal byte array.
//               - Returns read data and a Y86 status code (1 = AOK, 3 = ADR).
//               - Accesses are little-endian: byte at the request address is
//                 the least-significant byte.
// Parameters  : MEM_BYTES   - byte-array size; addresses 0..MEM_BYTES-1
//               WAIT_CYCLES - extra cycles between acceptance and response
//                             (0..15)
// Options     : DMEM_ALIGN_CHECK_EN - when defined, any address with
//               addr[2:0] != 0 is also reported as ADR.
// Ports       : clk_i        clock, all state changes on posedge
//               rst_ni       synchronous active-low reset
//               req_valid_i  request present
//               req_ready_o  responder can accept a request (IDLE only)
//               req_write_i  1 = write 8 bytes, 0 = read 8 bytes
//               req_addr_i   address of the least-significant byte
//               req_wdata_i  write data
//               rsp_valid_o  response present
//               rsp_ready_i  requester takes the response
//               rsp_rdata_o  read data (0 for writes and errors)
//               rsp_stat_o   1 = AOK, 3 = ADR
// Revision    : 1.0 - initial release
// ============================================================================
module y86_dmem_responder #(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic [2:0]  rsp_stat_o
);

    localparam int          ADDR_W      = $clog2(MEM_BYTES);
    // Highest address at which all 8 bytes still fit. Comparing against this
    // (rather than computing addr+7) keeps the check free of 64-bit overflow.
    localparam logic [63:0] c_last_ok   = 64'(MEM_BYTES - 8);
    localparam logic [3:0]  c_wait_load = 4'(WAIT_CYCLES);
    localparam logic [2:0]  c_stat_aok  = 3'd1;
    localparam logic [2:0]  c_stat_adr  = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q,  addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic [2:0]  stat_q,  stat_d;

    logic [7:0]  mem_q [MEM_BYTES];

    logic [ADDR_W-1:0] w_idx [8];
    logic [63:0]       w_rdata;
    logic              w_err;
    logic              w_commit;
    logic              w_mem_we;

    // Byte lane addresses of the latched request. When the request is out of
    // range these wrap harmlessly; the error path never uses them.
    for (genvar g = 0; g < 8; g++) begin : g_byte
        assign w_idx[g]           = addr_q[ADDR_W-1:0] + ADDR_W'(g);
        assign w_rdata[8*g +: 8]  = mem_q[w_idx[g]];
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = (addr_q > c_last_ok) || (addr_q[2:0] != 3'b000);
`else
    assign w_err = (addr_q > c_last_ok);
`endif

    // The access is committed on the edge that moves WAIT -> RESP.
    assign w_commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
    // Gated by reset so a reset landing on the commit edge writes nothing.
    assign w_mem_we = w_commit && write_q && !w_err && rst_ni;

    // Ready depends on state and reset only, never on req_valid_i.
    assign req_ready_o = rst_ni && (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_stat_o  = stat_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stat_d  = stat_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_WAIT;
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = c_wait_load;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (w_err) begin
                        rdata_d = 64'd0;
                        stat_d  = c_stat_adr;
                    end else begin
                        rdata_d = write_q ? 64'd0 : w_rdata;
                        stat_d  = c_stat_aok;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            stat_q  <= c_stat_aok;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            stat_q  <= stat_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[w_idx[i]] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y86_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_dmem_responder
// Description : Directed, table-driven bench for y86_dmem_responder.
//               One instance with WAIT_CYCLES=2 runs the vector table and the
//               multi-cycle sequences; a second with WAIT_CYCLES=0 checks
//               streaming throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WAIT_CYCLES = 2 instance
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr  = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic [2:0]  rsp_stat;

    // WAIT_CYCLES = 0 instance
    logic        z_rst_n     = 1'b0;
    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_rsp_valid;
    logic        z_rsp_ready = 1'b1;
    logic [63:0] z_rsp_rdata;
    logic [2:0]  z_rsp_stat;

    y86_dmem_responder #(.MEM_BYTES(1024), .WAIT_CYCLES(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_stat_o  (rsp_stat)
    );

    y86_dmem_responder #(.MEM_BYTES(1024), .WAIT_CYCLES(0)) dut0 (
        .clk_i       (clk),
        .rst_ni      (z_rst_n),
        .req_valid_i (z_req_valid),
        .req_ready_o (z_req_ready),
        .req_write_i (1'b0),
        .req_addr_i  (64'h40),
        .req_wdata_i (64'd0),
        .rsp_valid_o (z_rsp_valid),
        .rsp_ready_i (z_rsp_ready),
        .rsp_rdata_o (z_rsp_rdata),
        .rsp_stat_o  (z_rsp_stat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic [2:0]  exp_stat;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    // Issue one request with rsp_ready=1. Called just after a posedge with
    // the DUT in IDLE; returns just after the response handshake edge.
    // lat = number of edges after the accepting edge until rsp_valid is seen.
    task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic [2:0] st, output int lat,
                       output logic ok);
        logic acc = 1'b0;
        logic got = 1'b0;
        rd = '0; st = '0; lat = -1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int k = 0; k < 40 && acc && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; lat = k; rd = rsp_rdata; st = rsp_stat;
            end
            @(posedge clk); #1;
        end
        ok = acc && got;
    endtask

    initial begin
        logic [63:0] rd;
        logic [2:0]  st;
        int          lat;
        logic        ok;
        logic        done;
        int          last;
        int          nrsp;

        //             wr    addr                    wdata                  exp_rdata              stat
        tbl[0] = '{1'b1, 64'h10,                 64'h1122334455667788, 64'h0,                 3'd1};
        tbl[1] = '{1'b0, 64'h10,                 64'h0,                 64'h1122334455667788, 3'd1};
        tbl[2] = '{1'b1, 64'h0,                  64'h0807060504030201, 64'h0,                 3'd1};
        tbl[3] = '{1'b1, 64'h3F8,                64'hDEADBEEFCAFEF00D, 64'h0,                 3'd1};
        tbl[4] = '{1'b0, 64'h3F8,                64'h0,                 64'hDEADBEEFCAFEF00D, 3'd1};
        tbl[5] = '{1'b0, 64'h3F9,                64'h0,                 64'h0,                 3'd3};
        tbl[6] = '{1'b1, 64'hFFFFFFFFFFFFFFFC,   64'hFFFFFFFFFFFFFFFF, 64'h0,                 3'd3};
        tbl[7] = '{1'b0, 64'h0,                  64'h0,                 64'h0807060504030201, 3'd1};
        tbl[8] = '{1'b1, 64'h18,                 64'h0000000000000099, 64'h0,                 3'd1};
`ifdef DMEM_ALIGN_CHECK_EN
        tbl[9] = '{1'b0, 64'h11,                 64'h0,                 64'h0,                 3'd3};
`else
        tbl[9] = '{1'b0, 64'h11,                 64'h0,                 64'h9911223344556677, 3'd1};
`endif

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_stat",  {61'd0, rsp_stat},  64'd1);
        chk("rst_rsp_rdata", rsp_rdata,          64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;

        // ---- vector table ----
        for (int v = 0; v < NVEC; v++) begin
            txn(tbl[v].wr, tbl[v].addr, tbl[v].wdata, rd, st, lat, ok);
            chk($sformatf("vec%0d_handshake", v), {63'd0, ok}, 64'd1);
            chk($sformatf("vec%0d_rdata", v), rd, tbl[v].exp_rdata);
            chk($sformatf("vec%0d_stat", v), {61'd0, st}, {61'd0, tbl[v].exp_stat});
            chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd3);
            if (v == 0) begin
                chk("mem10", {56'd0, dut.mem_q[16]}, 64'h88);
                chk("mem17", {56'd0, dut.mem_q[23]}, 64'h11);
            end
        end
        // Out-of-range write at 2^64-4 must not have wrapped into bytes 0..3.
        chk("mem0_kept", {56'd0, dut.mem_q[0]}, 64'h01);
        chk("mem3_kept", {56'd0, dut.mem_q[3]}, 64'h04);

        // ---- back-pressure ----
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; rsp_ready = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bp_accept", {63'd0, done}, 64'd1);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("bp_rsp_seen", {63'd0, done}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("bp%0d_valid", c), {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("bp%0d_rdata", c), rsp_rdata, 64'h1122334455667788);
            chk($sformatf("bp%0d_stat", c),  {61'd0, rsp_stat}, 64'd1);
            chk($sformatf("bp%0d_req_ready", c), {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_release_valid", {63'd0, rsp_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;

        // ---- reset during WAIT of a write ----
        txn(1'b1, 64'h20, 64'h0123456789ABCDEF, rd, st, lat, ok);
        chk("pre20_stat", {61'd0, st}, 64'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        chk("rw_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;                       // accepted, now in WAIT
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rw_rsp_stat",  {61'd0, rsp_stat},  64'd1);
        chk("rw_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        txn(1'b0, 64'h20, 64'h0, rd, st, lat, ok);
        chk("rw_read_ok", {63'd0, ok}, 64'd1);
        chk("rw_read_data", rd, 64'h0123456789ABCDEF);

        // ---- WAIT_CYCLES=0 streaming ----
        z_req_valid = 1'b1; z_rsp_ready = 1'b1; z_rst_n = 1'b1;
        last = -1; nrsp = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (z_rsp_valid) begin
                nrsp++;
                chk($sformatf("z%0d_stat", c), {61'd0, z_rsp_stat}, 64'd1);
                if (last >= 0) chk($sformatf("z%0d_spacing", c), 64'(c - last), 64'd3);
                last = c;
            end
            @(posedge clk); #1;
        end
        chk("z_count", 64'(nrsp), 64'd10);
        z_req_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
